// File: rtl/reset_sequencer_pkg.sv
// reset_sequencer_pkg: state encoding, default parameters and counter sizing for reset_sequencer
package reset_sequencer_pkg;
  typedef enum logic [1:0] {ASSERT = 2'd0, HOLD = 2'd1, RELEASE = 2'd2, RUN = 2'd3} state_t;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_NUM_OUT = 4;
  localparam int DEF_MIN_PULSE = 16;
  localparam int DEF_STAGGER = 8;
  function automatic int cnt_bits(input int min_pulse, input int num_out, input int stagger);
    int m = (num_out - 1) * stagger + 1;
    return $clog2(min_pulse > m ? min_pulse : m) + 1;
  endfunction
endpackage

// File: rtl/rst_sync.sv
// rst_sync: async-assert, sync-deassert reset chain of SYNC_STAGES flops
// Ports: clk clock, rst_n async active-low reset in, sync_n synchronized reset release out.
module rst_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic sync_n
);
  logic [SYNC_STAGES-1:0] s;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) s <= '0;
    else s <= {s[SYNC_STAGES-2:0], 1'b1};
  assign sync_n = s[SYNC_STAGES-1];
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: staggered release of NUM_OUT active-low resets after RN, with optional soft reset
// Ports: CK clock, RN async active-low reset, SRST_REQ/SRST_ACK four-phase soft-reset handshake,
//        RN_OUT sequenced resets, READY all released, STATE current FSM encoding.
// Build option: define RST_SEQ_SOFT_EN to compile in the soft-reset path; otherwise SRST_ACK is 0.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int NUM_OUT = DEF_NUM_OUT,
  parameter int MIN_PULSE = DEF_MIN_PULSE,
  parameter int STAGGER = DEF_STAGGER
) (
  input  logic               CK,
  input  logic               RN,
  input  logic               SRST_REQ,
  output logic               SRST_ACK,
  output logic [NUM_OUT-1:0] RN_OUT,
  output logic               READY,
  output logic [1:0]         STATE
);
  localparam int CW = cnt_bits(MIN_PULSE, NUM_OUT, STAGGER);
  state_t st;
  logic rn_sync, ack;
  logic [CW-1:0] cnt, inc;
  logic [NUM_OUT-1:0] fill;
  rst_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (.clk(CK), .rst_n(RN), .sync_n(rn_sync));
  assign inc = &cnt ? cnt : cnt + 1'b1;
  // bits whose release point is reached once the counter advances; OR-ing keeps release monotonic
  for (genvar i = 0; i < NUM_OUT; i++) begin : g_fill
    assign fill[i] = 32'(inc) >= i * STAGGER;
  end
`ifndef RST_SEQ_SOFT_EN
  logic unused_req;
  assign unused_req = SRST_REQ;
`endif
  always_ff @(posedge CK or negedge RN)
    if (!RN) begin
      st <= ASSERT;
      cnt <= '0;
      RN_OUT <= '0;
      READY <= 1'b0;
      ack <= 1'b0;
    end else begin
      case (st)
        ASSERT: if (rn_sync) begin
          st <= HOLD;
          cnt <= '0;
        end
        HOLD: begin
`ifdef RST_SEQ_SOFT_EN
          ack <= ack & SRST_REQ;
`endif
          // the hold count only starts once the handshake has completed
          if (!ack && cnt == CW'(MIN_PULSE - 1)) begin
            st <= RELEASE;
            cnt <= '0;
            RN_OUT <= NUM_OUT'(1);
          end else if (!ack) cnt <= inc;
        end
        RELEASE: if (&RN_OUT) begin
          st <= RUN;
          READY <= 1'b1;
        end else begin
          cnt <= inc;
          RN_OUT <= RN_OUT | fill;
        end
        RUN: begin
`ifdef RST_SEQ_SOFT_EN
          if (SRST_REQ) begin
            st <= HOLD;
            cnt <= '0;
            RN_OUT <= '0;
            READY <= 1'b0;
            ack <= 1'b1;
          end
`endif
        end
      endcase
    end
  assign SRST_ACK = ack;
  assign STATE = st;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: checks power-on, mid-release reset, glitch, soft reset and small-parameter sequencing
`timescale 1ns/100ps
module tb_reset_sequencer;
  import reset_sequencer_pkg::*;
  localparam int SY = 2, MP = 16, ST = 8, NO = 4;
  typedef struct packed {
    logic [3:0] o;
    logic       r;
    logic [1:0] s;
    logic       a;
    logic       o1;
    logic       r1;
    logic [1:0] s1;
    logic       a1;
  } obs_t;
  typedef struct {
    int         k;
    logic [3:0] o;
    logic       r;
    logic [1:0] s;
    logic       o1;
    logic       r1;
    string      nm;
  } vec_t;
  logic CK = 1'b0, RN = 1'b1, req = 1'b0;
  logic ack0, rdy0, ack1, rdy1;
  logic [3:0] o0;
  logic [0:0] o1;
  logic [1:0] s0, s1;
  obs_t q[$];
  vec_t vec[11];
  int total = 0, bad = 0;
  int k = -1, off = 0, b = SY + MP;
  bit rn_low = 1'b0, hold_ack = 1'b0;
  reset_sequencer u0 (.CK(CK), .RN(RN), .SRST_REQ(req), .SRST_ACK(ack0), .RN_OUT(o0), .READY(rdy0), .STATE(s0));
  reset_sequencer #(.NUM_OUT(1), .MIN_PULSE(1), .STAGGER(1)) u1 (
    .CK(CK), .RN(RN), .SRST_REQ(1'b0), .SRST_ACK(ack1), .RN_OUT(o1), .READY(rdy1), .STATE(s1));
  always #5 CK = ~CK;
  function automatic obs_t now_obs();
    return {o0, rdy0, s0, ack0, o1, rdy1, s1, ack1};
  endfunction
  // k counts edges from 0 at the first edge sampling RN high; j is the same for the default DUT's current sequence
  function automatic obs_t expect_at();
    obs_t e = '0;
    int j = k - off;
    if (rn_low) return e;
    if (hold_ack) begin
      e.s = HOLD;
      e.a = 1'b1;
    end else begin
      for (int i = 0; i < NO; i++) e.o[i] = j >= b + i * ST;
      e.r = j >= b + (NO - 1) * ST + 1;
      e.s = j < b - MP ? ASSERT : j < b ? HOLD : e.r ? RUN : RELEASE;
    end
    e.o1 = k >= SY + 1;
    e.r1 = k >= SY + 2;
    e.s1 = k < SY ? ASSERT : k < SY + 1 ? HOLD : e.r1 ? RUN : RELEASE;
    return e;
  endfunction
  task automatic check(input string nm, input obs_t g, input obs_t e);
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL %s k=%0d got=%b want=%b", nm, k, g, e);
    end
  endtask
  task automatic tick(input string nm);
    obs_t e;
    if (!rn_low) k++;
    q.push_back(expect_at());
    @(posedge CK);
    #1;
    e = q.pop_front();
    check(nm, now_obs(), e);
  endtask
  task automatic release_rn();
    RN = 1'b1;
    rn_low = 1'b0;
    k = -1;
    off = 0;
    b = SY + MP;
    hold_ack = 1'b0;
  endtask
  task automatic pull_rn(input string nm);
    RN = 1'b0;
    rn_low = 1'b1;
    #1 check(nm, now_obs(), '0);
  endtask
  initial begin
    vec[0]  = '{1,  4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, "sync"};
    vec[1]  = '{2,  4'b0000, 1'b0, 2'd1, 1'b0, 1'b0, "hold_in"};
    vec[2]  = '{3,  4'b0000, 1'b0, 2'd1, 1'b1, 1'b0, "small_rel"};
    vec[3]  = '{4,  4'b0000, 1'b0, 2'd1, 1'b1, 1'b1, "small_rdy"};
    vec[4]  = '{17, 4'b0000, 1'b0, 2'd1, 1'b1, 1'b1, "hold_end"};
    vec[5]  = '{18, 4'b0001, 1'b0, 2'd2, 1'b1, 1'b1, "bit0"};
    vec[6]  = '{25, 4'b0001, 1'b0, 2'd2, 1'b1, 1'b1, "pre_bit1"};
    vec[7]  = '{26, 4'b0011, 1'b0, 2'd2, 1'b1, 1'b1, "bit1"};
    vec[8]  = '{34, 4'b0111, 1'b0, 2'd2, 1'b1, 1'b1, "bit2"};
    vec[9]  = '{42, 4'b1111, 1'b0, 2'd2, 1'b1, 1'b1, "bit3"};
    vec[10] = '{43, 4'b1111, 1'b1, 2'd3, 1'b1, 1'b1, "ready"};
    #2 pull_rn("por_async");
    repeat (5) tick("rn_low");
    #4 release_rn();
    for (int j = 0; j < 11; j++) begin
      while (k < vec[j].k) tick("por");
      total++;
      if ({o0, rdy0, s0, o1, rdy1} !== {vec[j].o, vec[j].r, vec[j].s, vec[j].o1, vec[j].r1}) begin
        bad++;
        $display("FAIL %s got=%b want=%b", vec[j].nm, {o0, rdy0, s0, o1, rdy1},
                 {vec[j].o, vec[j].r, vec[j].s, vec[j].o1, vec[j].r1});
      end
    end
    while (k < 50) tick("run");
`ifdef RST_SEQ_SOFT_EN
    #4 req = 1'b1;
    hold_ack = 1'b1;
    repeat (30) tick("srst_hold");
    #4 req = 1'b0;
    hold_ack = 1'b0;
    off = k + 1;
    b = MP;
    while (k - off < 45) tick("srst_rel");
`else
    #4 req = 1'b1;
    repeat (10) tick("srst_ignored");
    #4 req = 1'b0;
    repeat (2) tick("srst_ignored");
`endif
    #4 pull_rn("run_async");
    repeat (2) tick("rn_low2");
    #4 release_rn();
    while (k < 26) tick("pre_mid");
    #4 pull_rn("mid_async");
    repeat (2) tick("mid_low");
    #4 release_rn();
    while (k < 45) tick("mid_restart");
    #4 RN = 1'b0;
    rn_low = 1'b1;
    #0.5 check("glitch_async", now_obs(), '0);
    #0.5 release_rn();
    while (k < 45) tick("glitch_restart");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on RN deassertion (legal range 2..4).
REQ-002 SHALL have parameter NUM_OUT, default 4, number of sequenced active-low reset outputs (legal range 1..8).
REQ-003 SHALL have parameter MIN_PULSE, default 16, number of cycles all outputs stay asserted after reset release (legal range 1..255).
REQ-004 SHALL have parameter STAGGER, default 8, number of cycles between consecutive output releases (legal range 1..255).
REQ-005 SHALL have port CK, input, 1 bit: the single clock; all flops are rising-edge.
REQ-006 SHALL have port RN, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port SRST_REQ, input, 1 bit: synchronous soft-reset request, level, four-phase.
REQ-008 SHALL have port SRST_ACK, output, 1 bit: soft-reset acknowledge.
REQ-009 SHALL have port RN_OUT, output, NUM_OUT bits: active-low resets for downstream domains.
REQ-010 SHALL have port READY, output, 1 bit: high only when all RN_OUT bits are released.
REQ-011 SHALL have port STATE, output, 2 bits: current FSM state encoding.

Function
REQ-012 SHALL implement FSM states ASSERT=0, HOLD=1, RELEASE=2, RUN=3.
REQ-013 SHALL synchronize RN deassertion through SYNC_STAGES flops, forming rn_sync; RN assertion SHALL clear rn_sync immediately and asynchronously.
REQ-014 SHALL transition ASSERT->HOLD on the first CK edge sampling rn_sync=1, clearing the counter.
REQ-015 SHALL remain in HOLD for exactly MIN_PULSE cycles with all RN_OUT=0, then enter RELEASE with the counter cleared.
REQ-016 In RELEASE, SHALL drive RN_OUT[i]=1 registered from the edge at which counter==i*STAGGER; release order is index 0 first and is never reversed.
REQ-017 SHALL enter RUN one cycle after RN_OUT[NUM_OUT-1] releases; READY SHALL be registered high on that edge.
REQ-018 In RUN, SRST_REQ=1 SHALL drive all RN_OUT=0 and READY=0 on the next edge, and SHALL enter HOLD.
REQ-019 SRST_ACK SHALL rise on that same edge and stay high until SRST_REQ is sampled 0; HOLD SHALL not exit while SRST_ACK=1, and SRST_ACK SHALL fall on the edge that samples SRST_REQ=0.
REQ-020 SHALL ignore SRST_REQ in ASSERT, HOLD (beyond the handshake) and RELEASE.
REQ-021 The counter SHALL be sized to $clog2(max(MIN_PULSE,(NUM_OUT-1)*STAGGER+1))+1 bits, SHALL saturate, and SHALL never wrap.

Reset
REQ-022 RN=0 at any time, including mid-RELEASE or mid-handshake, SHALL asynchronously force ASSERT, RN_OUT=0, READY=0, SRST_ACK=0 and counter=0.
REQ-023 RN deassertion SHALL never release any RN_OUT earlier than SYNC_STAGES+MIN_PULSE edges after it.

Configuration
REQ-024 Macro RST_SEQ_SOFT_EN defined SHALL compile in the soft-reset path (REQ-018/019).
REQ-025 Without RST_SEQ_SOFT_EN, SRST_REQ SHALL be unused, SRST_ACK SHALL be tied 0, and RUN SHALL exit only on RN.

Structure
REQ-026 Package reset_sequencer_pkg SHALL hold the state enum and the default parameter constants.
REQ-027 The synchronizer SHALL be a sub-module rst_sync (async-assert, sync-deassert chain, parameter SYNC_STAGES).

Verification
REQ-028 Power-on test: RN low 5 cycles, then high -> RN_OUT=4'b0000 until edge 2+16; bits release at offsets 0, 8, 16, 24; READY=1 one cycle after bit 3 releases.
REQ-029 Mid-release reset test: RN pulsed low after RN_OUT=4'b0011 -> RN_OUT=0 and STATE=0 with no clock edge; the full sequence then restarts.
REQ-030 Soft reset test: SRST_REQ=1 in RUN for 30 cycles -> next edge RN_OUT=0 and SRST_ACK=1; HOLD is held until REQ drops, then 16 cycles, then the staggered release.
REQ-031 Glitch test: RN low for 1 ns between edges -> asynchronous RN_OUT=0 and a full restart; no partial release.
REQ-032 Parameter test: NUM_OUT=1, MIN_PULSE=1, STAGGER=1 -> RN_OUT releases on edge SYNC_STAGES+1 and READY follows one cycle later.
REQ-033 Macro test: without RST_SEQ_SOFT_EN, SRST_REQ=1 in RUN -> no change, and SRST_ACK stays 0.
